// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: control from EX/pipeline controller, byte-wide memory
// port, and the {pc, inst, valid} presentation toward decode.
interface if_fetch_if;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        mem_grant_i;
  logic [7:0]  mem_din_i;
  logic [31:0] mem_a_o;
  logic        mem_rd_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  // Environment side: pipeline control and memory controller drive this
  modport master (
    output stall_i, br_taken_i, br_target_i, mem_grant_i, mem_din_i,
    input  mem_a_o, mem_rd_o, pc_o, inst_o, inst_valid_o
  );

  // Fetch unit side
  modport slave (
    input  stall_i, br_taken_i, br_target_i, mem_grant_i, mem_din_i,
    output mem_a_o, mem_rd_o, pc_o, inst_o, inst_valid_o
  );
endinterface

// File: rtl/if_fetch.sv
// RV32I instruction fetch: assembles each 32-bit word from four byte reads on a
// shared 8-bit port and holds {pc, inst, valid} until decode accepts.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst,
  if_fetch_if.slave bus
);

  typedef enum logic {FETCH, DONE} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [2:0]  issue_cnt;
  logic [2:0]  recv_cnt;
  logic        pending;
  logic [7:0]  byte_q [3];
  logic [31:0] pc_p0;
  logic [31:0] inst_p0;
  logic        vld_p0;

  logic issue;
  logic capture;

  // rst is in the request term so an asynchronous reset drops the read at once
  assign bus.mem_rd_o = (state == FETCH) && (issue_cnt < 3'd4) && !bus.br_taken_i && rst;
  assign bus.mem_a_o  = fetch_pc + {29'd0, issue_cnt};
  assign issue        = bus.mem_rd_o && bus.mem_grant_i;
  assign capture      = pending && !bus.br_taken_i;

  assign bus.pc_o         = pc_p0;
  assign bus.inst_o       = inst_p0;
  assign bus.inst_valid_o = vld_p0;

  // Lower three bytes are staged here; the fourth goes straight into inst_p0
  always_ff @(posedge clk) begin
    if (capture && (recv_cnt < 3'd3)) begin
      byte_q[recv_cnt[1:0]] <= bus.mem_din_i;
    end
  end

  // Stage p0: control FSM and registered presentation to decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      issue_cnt <= 3'd0;
      recv_cnt  <= 3'd0;
      pending   <= 1'b0;
      pc_p0     <= RESET_PC;
      inst_p0   <= 32'd0;
      vld_p0    <= 1'b0;
    end else if (bus.br_taken_i) begin
      // Redirect wins over stall, handshake and a completing capture
      state     <= FETCH;
      fetch_pc  <= bus.br_target_i;
      issue_cnt <= 3'd0;
      recv_cnt  <= 3'd0;
      pending   <= 1'b0;
      vld_p0    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          pending <= issue;
          if (issue) begin
            issue_cnt <= issue_cnt + 3'd1;
          end
          if (capture) begin
            recv_cnt <= recv_cnt + 3'd1;
            if (recv_cnt == 3'd3) begin
              state   <= DONE;
              vld_p0  <= 1'b1;
              pc_p0   <= fetch_pc;
              inst_p0 <= {bus.mem_din_i, byte_q[2], byte_q[1], byte_q[0]};
            end
          end
        end
        DONE: begin
          if (!bus.stall_i) begin
            state     <= FETCH;
            fetch_pc  <= fetch_pc + 32'd4;
            issue_cnt <= 3'd0;
            recv_cnt  <= 3'd0;
            pending   <= 1'b0;
            vld_p0    <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed latency/redirect/reset scenarios plus a random
// grant/stall/redirect run scored against a transaction-level fetch model.
module tb_if_fetch;

  logic clk;
  logic rst;
  if_fetch_if bus();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [7:0] mem [256];
  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: returns the addressed byte the cycle after a granted read, else noise
  always @(posedge clk) begin
    if (bus.mem_rd_o && bus.mem_grant_i) bus.mem_din_i <= mem[bus.mem_a_o[7:0]];
    else                                 bus.mem_din_i <= 8'($urandom);
  end

  function automatic logic [31:0] word_at(logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mem[a3[7:0]], mem[a2[7:0]], mem[a1[7:0]], mem[a[7:0]]};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit g, bit s, bit b, logic [31:0] t);
    bus.mem_grant_i = g;
    bus.stall_i     = s;
    bus.br_taken_i  = b;
    bus.br_target_i = t;
    #1;
  endtask

  // Leaves the bench in cycle 0 with reset just released
  task automatic do_reset();
    rst = 1'b0;
    drive(1, 0, 0, 0);
    tick();
    tick();
    check("rst_pc", bus.pc_o, 32'h0);
    check("rst_inst", bus.inst_o, 32'h0);
    check("rst_vld", {31'd0, bus.inst_valid_o}, 32'd0);
    check("rst_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    check("rst_addr", bus.mem_a_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int          exp_pc_i;
  logic [31:0] exp_pc;
  int          n_iss;
  int          t4;
  bit          presenting;
  bit          exp_rd;
  bit          g, s, b;
  logic [31:0] tgt;

  initial begin
    rst = 1'b0;
    bus.mem_grant_i = 1'b1;
    bus.stall_i     = 1'b0;
    bus.br_taken_i  = 1'b0;
    bus.br_target_i = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

    // Full grant, no stall
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) tick();
      drive(1, 0, 0, 0);
      if (c <= 3) begin
        check("t1_rd", {31'd0, bus.mem_rd_o}, 32'd1);
        check("t1_addr", bus.mem_a_o, 32'(c));
      end
      if (c == 4) check("t1_vld4", {31'd0, bus.inst_valid_o}, 32'd0);
      if (c == 5) begin
        check("t1_vld", {31'd0, bus.inst_valid_o}, 32'd1);
        check("t1_inst", bus.inst_o, 32'h0010_0513);
        check("t1_pc", bus.pc_o, 32'h0);
      end
      if (c == 6) begin
        check("t1_addr6", bus.mem_a_o, 32'h4);
        check("t1_vld6", {31'd0, bus.inst_valid_o}, 32'd0);
      end
    end

    // Stall for cycles 5-8
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) tick();
      drive(1, (c >= 5 && c <= 8), 0, 0);
      if (c >= 5 && c <= 9) begin
        check("t2_vld", {31'd0, bus.inst_valid_o}, 32'd1);
        check("t2_inst", bus.inst_o, 32'h0010_0513);
        check("t2_pc", bus.pc_o, 32'h0);
        check("t2_rd", {31'd0, bus.mem_rd_o}, 32'd0);
      end
      if (c == 10) begin
        check("t2_addr", bus.mem_a_o, 32'h4);
        check("t2_rd10", {31'd0, bus.mem_rd_o}, 32'd1);
      end
    end

    // No grant in cycles 1 and 2
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) tick();
      drive(!(c == 1 || c == 2), 0, 0, 0);
      if (c >= 1 && c <= 3) check("t3_hold", bus.mem_a_o, 32'h1);
      if (c == 3) check("t3_rd", {31'd0, bus.mem_rd_o}, 32'd1);
      if (c == 6) check("t3_vld6", {31'd0, bus.inst_valid_o}, 32'd0);
      if (c == 7) begin
        check("t3_vld", {31'd0, bus.inst_valid_o}, 32'd1);
        check("t3_inst", bus.inst_o, word_at(32'h0));
      end
    end

    // Redirect to 0x100 in cycle 2
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) tick();
      drive(1, 0, (c == 2), 32'h100);
      if (c == 2) check("t4_rd", {31'd0, bus.mem_rd_o}, 32'd0);
      if (c >= 3 && c <= 6) check("t4_addr", bus.mem_a_o, 32'h100 + 32'(c - 3));
      if (c <= 7) check("t4_novld", {31'd0, bus.inst_valid_o}, 32'd0);
      if (c == 8) begin
        check("t4_pc", bus.pc_o, 32'h100);
        check("t4_inst", bus.inst_o, word_at(32'h100));
      end
    end

    // Redirect to the top of the address space, then wrap after accept
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) tick();
      drive(1, 0, (c == 0), 32'hFFFF_FFFC);
      if (c >= 1 && c <= 4) check("t5_addr", bus.mem_a_o, 32'hFFFF_FFFC + 32'(c - 1));
      if (c == 6) begin
        check("t5_pc", bus.pc_o, 32'hFFFF_FFFC);
        check("t5_inst", bus.inst_o, word_at(32'hFFFF_FFFC));
      end
      if (c == 7) check("t5_wrap", bus.mem_a_o, 32'h0);
      if (c == 12) check("t5_pc0", bus.pc_o, 32'h0);
    end

    // Asynchronous reset in the middle of a fetch at 0x40
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) tick();
      drive(1, 0, (c == 6), 32'h40);
    end
    check("t6_pre", bus.mem_a_o, 32'h42);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    check("t6_addr", bus.mem_a_o, 32'h0);
    check("t6_inst", bus.inst_o, 32'h0);
    check("t6_pc", bus.pc_o, 32'h0);
    tick();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) tick();
      drive(1, 0, 0, 0);
      if (c == 4) check("t6_novld", {31'd0, bus.inst_valid_o}, 32'd0);
      if (c == 5) check("t6_word", bus.inst_o, word_at(32'h0));
    end

    // Random grant/stall/redirect against the transaction model
    do_reset();
    exp_pc = 32'h0;
    n_iss = 0;
    t4 = -1;
    presenting = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) tick();
      g   = ($urandom_range(3) != 0);
      s   = ($urandom_range(2) == 0);
      b   = ($urandom_range(15) == 0);
      tgt = $urandom;
      drive(g, s, b, tgt);
      if (t4 >= 0 && c == t4 + 2) begin
        presenting = 1;
        t4 = -1;
      end
      check("r_vld", {31'd0, bus.inst_valid_o}, {31'd0, presenting});
      if (presenting) begin
        check("r_pc", bus.pc_o, exp_pc);
        check("r_inst", bus.inst_o, word_at(exp_pc));
      end
      exp_rd = !presenting && (n_iss < 4) && !b;
      check("r_rd", {31'd0, bus.mem_rd_o}, {31'd0, exp_rd});
      if (exp_rd) check("r_addr", bus.mem_a_o, exp_pc + 32'(n_iss));
      if (b) begin
        exp_pc = tgt;
        n_iss = 0;
        presenting = 0;
        t4 = -1;
      end else if (presenting && !s) begin
        exp_pc = exp_pc + 32'd4;
        n_iss = 0;
        presenting = 0;
      end else if (exp_rd && g) begin
        n_iss++;
        if (n_iss == 4) t4 = c;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
